// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the core front end.
`default_nettype none

package core_pkg;

  localparam int CORE_XLEN = 32;
  localparam int PC_STEP   = 4;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/core_fetch_fifo.sv
// ---------------------------------------------------------------------
// core_fetch_fifo: synchronous FIFO with flush, count and registered storage.
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

module core_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Empty reads return zero so stale storage never leaks onto the outputs.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/core_fetch.sv
// ---------------------------------------------------------------------
// core_fetch: in-order instruction fetch with credit-limited issue and redirect.
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

module core_fetch
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 3
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            f_valid,
  output logic [XLEN-1:0] f_pc,
  output logic [XLEN-1:0] f_instr,
  input  logic            d_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0]   pc_q;
  logic [CW-1:0]     drop_q;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     buf_count;
  logic              pcf_full;
  logic              pcf_empty;
  logic [XLEN-1:0]   pcf_head;
  logic              buf_full;
  logic              buf_empty;
  logic              buf_push;
  logic              buf_pop;
  logic              req_fire;
  logic [2*XLEN-1:0] buf_head;

  // Credit: outstanding requests plus buffered entries never exceed DEPTH.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, inflight} + {1'b0, buf_count}) < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign buf_push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign buf_pop  = f_valid && !d_stall && !redirect_valid;

  assign f_valid  = !rst && !buf_empty;
  assign f_pc     = f_valid ? buf_head[2*XLEN-1:XLEN] : '0;
  assign f_instr  = f_valid ? buf_head[XLEN-1:0]      : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc & ~(XLEN'(3));
      drop_q <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_q <= pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid && (drop_q != '0)) drop_q <= drop_q - CW'(1);
    end
  end

  // Its occupancy is the in-flight count, so no separate counter is kept.
  core_fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (imem_rsp_valid),
    .pop_data  (pcf_head),
    .full      (pcf_full),
    .empty     (pcf_empty),
    .count     (inflight)
  );

  core_fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_buf_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data ({pcf_head, imem_rsp_data}),
    .pop       (buf_pop),
    .pop_data  (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> !pcf_empty);
  pc_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> !pcf_full);
  buffer_overflow: assert property (@(posedge clk) disable iff (rst)
    buf_push |-> !buf_full);
  drop_bounded: assert property (@(posedge clk) disable iff (rst)
    drop_q <= inflight);

endmodule

`default_nettype wire

// File: tb/tb_core_fetch.sv
// tb_core_fetch: directed table, hand sequences and randomized run against a fetch-stream model.
`default_nettype none

module tb_core_fetch;
  import core_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        d_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  core_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_instr        (f_instr),
    .d_stall        (d_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: in-order responses, latency drawn from [mem_lat_lo, mem_lat_hi].
  int mem_ready_pct = 100;
  int mem_lat_lo    = 1;
  int mem_lat_hi    = 1;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  initial begin : memory_model
    int     cyc;
    pend_t  p;
    logic   fire, rsp_taken, was_rst;
    logic [31:0] addr;
    cyc = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      was_rst   = rst;
      fire      = imem_req_valid && imem_req_ready;
      addr      = imem_req_addr;
      rsp_taken = imem_rsp_valid;
      @(posedge clk);
      #1;
      cyc++;
      if (was_rst) pend.delete();
      else begin
        if (rsp_taken && pend.size() > 0) void'(pend.pop_front());
        if (fire) begin
          p.addr = addr;
          p.due  = cyc + int'($urandom_range(mem_lat_hi, mem_lat_lo)) - 1;
          pend.push_back(p);
        end
      end
      imem_req_ready = (int'($urandom_range(99, 0)) < mem_ready_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Reference: the fetch stream is a linear PC walk restarted by reset or redirect.
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] exp_pc  = RESET_PC;
  int          outstanding = 0;

  initial begin : scoreboard
    fetch_entry_t got;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_req     = RESET_PC;
        exp_pc      = RESET_PC;
        outstanding = 0;
      end else begin
        if (redirect_valid) check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_req);
          check("credit", 32'(outstanding < DEPTH), 32'd1);
          exp_req += 32'(PC_STEP);
          outstanding++;
        end
        if (imem_rsp_valid) outstanding--;
        if (f_valid && !d_stall && !redirect_valid) begin
          got.pc    = f_pc;
          got.instr = f_instr;
          check("pop_pc", got.pc, exp_pc);
          check("pop_instr", got.instr, mem_word(exp_pc));
          exp_pc += 32'(PC_STEP);
        end
        if (redirect_valid) begin
          exp_req = redirect_pc & ~32'h3;
          exp_pc  = redirect_pc & ~32'h3;
        end
      end
    end
  end

  task automatic wait_f_valid(input string name, input int max_cycles);
    int n = 0;
    @(negedge clk);
    while (!f_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(f_valid), 32'd1);
  endtask

  typedef struct {
    logic [31:0] target;
    int          lat;
    bit          stall;
    int          min_out;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs[5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] held;
    int          n;
    vecs[0] = '{target: 32'h0000_0100, lat: 3, stall: 1'b0, min_out: 2, exp_addr: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_2000, lat: 1, stall: 1'b1, min_out: 1, exp_addr: 32'h0000_2000};
    vecs[2] = '{target: 32'h0000_0103, lat: 1, stall: 1'b0, min_out: 1, exp_addr: 32'h0000_0100};
    vecs[3] = '{target: 32'hFFFF_FFFE, lat: 2, stall: 1'b0, min_out: 1, exp_addr: 32'hFFFF_FFFC};
    vecs[4] = '{target: 32'h0000_0ABD, lat: 1, stall: 1'b1, min_out: 1, exp_addr: 32'h0000_0ABC};

    rst = 1'b1; d_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_f_valid", 32'(f_valid), 32'd0);
    check("rst_f_pc", f_pc, 32'd0);
    check("rst_f_instr", f_instr, 32'd0);

    // Back-to-back stream with 1-cycle memory.
    step(); rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    check("latency_not_yet", 32'(f_valid), 32'd0);
    @(negedge clk);
    check("latency_f_valid", 32'(f_valid), 32'd1);
    check("latency_f_pc", f_pc, RESET_PC);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("stream_valid", 32'(f_valid), 32'd1);
      check("stream_pc", f_pc, RESET_PC + 32'(4 * i));
    end

    // Five-cycle decode stall.
    step(); d_stall = 1'b1;
    @(negedge clk);
    held = f_pc;
    check("stall_valid", 32'(f_valid), 32'd1);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold_pc", f_pc, held);
      check("stall_hold_instr", f_instr, mem_word(held));
    end
    check("stall_credit_stop", 32'(imem_req_valid), 32'd0);
    step(); d_stall = 1'b0;
    @(negedge clk);
    check("release_pc0", f_pc, held);
    @(negedge clk);
    check("release_valid", 32'(f_valid), 32'd1);
    check("release_pc1", f_pc, held + 32'd4);

    // Redirect table.
    foreach (vecs[v]) begin
      mem_lat_lo = vecs[v].lat;
      mem_lat_hi = vecs[v].lat;
      step();
      n = 0;
      while (outstanding < vecs[v].min_out && n < 20) begin
        step();
        n++;
      end
      check("redir_precondition", 32'(outstanding >= vecs[v].min_out), 32'd1);
      redirect_valid = 1'b1; redirect_pc = vecs[v].target; d_stall = vecs[v].stall;
      @(negedge clk);
      check("redir_cycle_no_req", 32'(imem_req_valid), 32'd0);
      step(); redirect_valid = 1'b0; d_stall = 1'b0;
      @(negedge clk);
      check("redir_flushed", 32'(f_valid), 32'd0);
      check("redir_req_valid", 32'(imem_req_valid), 32'd1);
      check("redir_req_addr", imem_req_addr, vecs[v].exp_addr);
      wait_f_valid("redir_f_valid_timeout", 15);
      check("redir_f_pc", f_pc, vecs[v].exp_addr);
      check("redir_f_instr", f_instr, mem_word(vecs[v].exp_addr));
      repeat (4) step();
    end

    // Reset with entries buffered.
    mem_lat_lo = 1; mem_lat_hi = 1;
    step(); d_stall = 1'b1;
    repeat (4) step();
    rst = 1'b1; d_stall = 1'b0;
    step(); rst = 1'b0;
    @(negedge clk);
    check("post_rst_f_valid", 32'(f_valid), 32'd0);
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, RESET_PC);

    // Randomized traffic against the stream model.
    mem_ready_pct = 70; mem_lat_lo = 1; mem_lat_hi = 4;
    for (int c = 0; c < 3000; c++) begin
      step();
      d_stall        = ($urandom_range(9, 0) < 3);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom;
    end
    step(); redirect_valid = 1'b0; d_stall = 1'b0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_fetch.md
# core_fetch

Instruction-fetch stage of the in-order core pipeline, directly upstream of decode. It owns the program counter, issues in-order requests to instruction memory, and buffers returned instructions. It presents one `{pc, instr}` per cycle to decode, holds it while decode stalls, and redirects and drops stale fetches when execute resolves a taken branch or jump.

## Interface
Parameters:
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, 3: instruction buffer entries, which is also the maximum of in-flight requests plus buffered entries. Must be at least 2.

Ports:
- `clk`  in  1  core clock; the block uses only this one clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  XLEN  fetch address, always word-aligned.
- `imem_rsp_valid`  in  1  response valid; responses return in order, at least 1 cycle after acceptance, with no backpressure.
- `imem_rsp_data`  in  XLEN  instruction word.
- `f_valid`  out  1  decode-facing entry valid.
- `f_pc`  out  XLEN  PC of the presented instruction.
- `f_instr`  out  XLEN  presented instruction.
- `d_stall`  in  1  decode stall from the hazard unit; hold the current entry.
- `redirect_valid`  in  1  execute redirect, for a taken branch, jump, or trap.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0.

## Operation
State:
- `pc`: next request address.
- `inflight`: count of accepted requests whose response has not returned.
- `drop`: count of in-flight responses to discard; `drop <= inflight` always holds.
- In-flight PC FIFO: `DEPTH` entries.
- Instruction buffer: a FIFO of `{pc, instr}`, `DEPTH` entries.

Issue:
- `imem_req_valid = !rst & !redirect_valid & (inflight + count < DEPTH)`.
- `imem_req_addr = pc`.
- On a request handshake: push `pc` into the in-flight PC FIFO, set `pc <= pc + 4` (wraps modulo 2^XLEN), and increment `inflight`.

Response:
- On `imem_rsp_valid`, decrement `inflight` and pop the in-flight PC FIFO.
- If `drop > 0`, discard the data and decrement `drop`.
- Otherwise push `{popped pc, imem_rsp_data}` into the buffer.

Output and pop:
- `f_valid` = buffer not empty.
- `f_pc` and `f_instr` = buffer head.
- Pop when `f_valid & !d_stall`.

Redirect takes priority over everything else:
- Buffer is cleared; no pop is counted.
- `pc <= {redirect_pc[XLEN-1:2], 2'b00}`.
- `drop <= inflight - (imem_rsp_valid ? 1 : 0)`.
- No request is issued in the redirect cycle.

Simultaneous events:
- Push and pop in the same cycle leaves the count unchanged.
- A response arriving in the redirect cycle is discarded.
- `d_stall` during a redirect has no effect.

Protocol violations are caught by assertions only:
- `imem_rsp_valid` while `inflight == 0`.
- A buffer push while the buffer is full; this cannot occur by the credit rule.

## Timing
- Reset state: `pc = RESET_PC`; `inflight`, `drop` and both FIFOs cleared.
- Outputs during and after reset: `imem_req_valid = 0`, `f_valid = 0`, `f_pc = 0`, `f_instr = 0`. The first request is issued in the first cycle after `rst` deasserts.
- Latency: request accepted at cycle N, response at N+1 or later, `f_valid` asserted the cycle after the response. Outputs are registered, with no combinational path from the response to `f_*`.
- Throughput: sustained 1 instruction per cycle with 1-cycle memory and `DEPTH >= 3`.
- Reset asserted mid-operation returns to the reset state the next cycle. Responses to requests issued before reset are the memory's responsibility; the memory is reset together with the core.
- First request to the target: one cycle after the redirect cycle.

## Structure
- In `core_pkg`:
  - typedef `fetch_entry_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;}`.
  - constant `PC_STEP = 4`.
- Sub-module `core_fetch_fifo`: a parameterised synchronous FIFO with a `flush` input, `count` output, and push/pop/full/empty. It is instantiated twice: once for in-flight PCs and once for the instruction buffer.
- Counters are `$clog2(DEPTH+1)` bits wide.

## Test plan
1. Reset, then memory with 1-cycle latency and `d_stall = 0`: `f_pc` runs 0x0, 0x4, 0x8, … back-to-back with no bubbles after the first.
2. `d_stall` held high for 5 cycles: `f_pc` and `f_instr` hold. `imem_req_valid` drops once `inflight + count == 3`. After release, the sequence continues with no gap or duplicate.
3. Redirect to 0x100 while 2 requests are in flight: both stale responses are discarded and the next `f_valid` shows `f_pc = 0x100`.
4. Redirect in the same cycle as a response and with `d_stall = 1`: that response is discarded, the buffer is empty the next cycle, and the target is fetched next.
5. Redirect to 0x103: `imem_req_addr = 0x100`.
6. `rst` asserted with 2 responses buffered: `f_valid = 0` the next cycle, and the first request after reset uses `imem_req_addr = RESET_PC`.
